// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding one shared LSB-first PISO shifter.
// Each frame is tagged with valid/last/source strobes and followed by GAP_CYCLES idle cycles.
module piso_tx_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            dout,
  output logic                            dout_valid,
  output logic                            dout_last,
  output logic [SRC_W-1:0]                dout_src,
  output logic                            busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bitcnt;
  logic [GAP_W-1:0]      gapcnt;
  logic [SRC_W-1:0]      ptr;

  logic [SRC_W-1:0]      grant_idx;
  logic [SRC_W-1:0]      cand;
  logic                  found;
  logic                  grant_en;
  logic                  grant;
  logic                  last_bit;

  assign last_bit = (state == SHIFT) && (bitcnt == CNT_W'(DATA_WIDTH - 1));

  // With no gap, the next winner is loaded on the same edge that retires the last bit.
  assign grant_en = resetn && ((state == IDLE) || ((GAP_CYCLES == 0) && last_bit));
  assign grant    = grant_en && found;

  // Search starts at ptr and wraps; the first pending requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  assign dout_valid = (state == SHIFT);
  assign dout       = dout_valid & shreg[0];
  assign dout_last  = last_bit;
  assign busy       = (state != IDLE);

  // NOTE: synchronous reset -- resetn is sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: state elements use non-blocking assignments so every register sees pre-edge values.
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      gapcnt   <= '0;
      ptr      <= '0;
      dout_src <= '0;
    end else if (grant) begin
      shreg    <= req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
      dout_src <= grant_idx;
      bitcnt   <= '0;
      ptr      <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      state    <= SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          shreg <= shreg >> 1;
          if (last_bit) begin
            bitcnt <= '0;
            gapcnt <= '0;
            state  <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        GAP: begin
          if (int'(gapcnt) == GAP_CYCLES - 1) state <= IDLE;
          else                                gapcnt <= gapcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: a GAP_CYCLES=1 and a GAP_CYCLES=0 instance share stimulus,
// both are checked every cycle against a frame-level reference model, plus directed sequences.
module tb_piso_tx_scheduler;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;

  logic [N-1:0]  a_ready, b_ready;
  logic          a_dout, a_valid, a_last, a_busy;
  logic          b_dout, b_valid, b_last, b_busy;
  logic [SW-1:0] a_src, b_src;

  piso_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .GAP_CYCLES(1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(a_ready), .dout(a_dout), .dout_valid(a_valid), .dout_last(a_last),
    .dout_src(a_src), .busy(a_busy)
  );

  piso_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .GAP_CYCLES(0)) dut_nogap (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_ready), .dout(b_dout), .dout_valid(b_valid), .dout_last(b_last),
    .dout_src(b_src), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is either being sent (pos = bit index on the wire),
  // in its trailing gap (gap_left > 0), or absent.
  typedef struct {
    int          pos;
    int          gap_left;
    int          ptr;
    int          src;
    logic [DW-1:0] word;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.pos = -1; m.gap_left = 0; m.ptr = 0; m.src = 0; m.word = '0;
    return m;
  endfunction

  function automatic int mdl_pick(mdl_t m, logic rn, logic [N-1:0] v, int gap);
    if (!rn) return -1;
    if (!((m.pos < 0 && m.gap_left == 0) || (gap == 0 && m.pos == DW - 1))) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m.ptr + k) % N;
      if (((v >> i) & 4'd1) != 4'd0) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, logic rn, logic [N-1:0] v, logic [N*DW-1:0] d, int gap);
    mdl_t n;
    int g;
    n = m;
    g = mdl_pick(m, rn, v, gap);
    if (!rn) return mdl_reset();
    if (g >= 0) begin
      n.pos = 0; n.src = g; n.ptr = (g + 1) % N; n.word = DW'(d >> (g * DW));
    end else if (m.pos == DW - 1) begin
      n.pos = -1; n.gap_left = gap;
    end else if (m.pos >= 0) begin
      n.pos = m.pos + 1;
    end else if (m.gap_left > 0) begin
      n.gap_left = m.gap_left - 1;
    end
    return n;
  endfunction

  mdl_t ma, mb;

  // Values observed in the most recent step, for directed checks.
  logic [N-1:0]  s_a_ready, s_b_ready;
  logic          s_a_dout, s_a_valid, s_a_last, s_a_busy;
  logic          s_b_dout, s_b_valid, s_b_last, s_b_busy;
  logic [SW-1:0] s_a_src, s_b_src;

  task automatic cmp_model(input string tag, input mdl_t m, input int gap,
                           input logic [N-1:0] rdy, input logic dv, input logic vl,
                           input logic ls, input logic [SW-1:0] sr, input logic bs);
    int g;
    logic [N-1:0] exp_rdy;
    g = mdl_pick(m, resetn, req_valid, gap);
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check({tag, ".req_ready"},  64'(rdy), 64'(exp_rdy));
    check({tag, ".dout_valid"}, 64'(vl),  64'(m.pos >= 0));
    check({tag, ".dout"},       64'(dv),  (m.pos >= 0) ? 64'((m.word >> m.pos) & 1) : 64'd0);
    check({tag, ".dout_last"},  64'(ls),  64'(m.pos == DW - 1));
    check({tag, ".dout_src"},   64'(sr),  64'(m.src));
    check({tag, ".busy"},       64'(bs),  64'(m.pos >= 0 || m.gap_left > 0));
  endtask

  // One clock cycle: drive inputs, sample and compare on the falling edge, advance models.
  task automatic step(input logic rn, input logic [N-1:0] v, input logic [N*DW-1:0] d);
    resetn = rn; req_valid = v; req_data = d;
    @(negedge clk);
    s_a_ready = a_ready; s_a_dout = a_dout; s_a_valid = a_valid; s_a_last = a_last;
    s_a_src = a_src; s_a_busy = a_busy;
    s_b_ready = b_ready; s_b_dout = b_dout; s_b_valid = b_valid; s_b_last = b_last;
    s_b_src = b_src; s_b_busy = b_busy;
    cmp_model("gap1", ma, 1, a_ready, a_dout, a_valid, a_last, a_src, a_busy);
    cmp_model("gap0", mb, 0, b_ready, b_dout, b_valid, b_last, b_src, b_busy);
    ma = mdl_next(ma, rn, v, d, 1);
    mb = mdl_next(mb, rn, v, d, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, 4'b1111, {4{16'hFFFF}});
    step(1'b0, 4'b1111, {4{16'hFFFF}});
  endtask

  typedef struct {
    logic         rn;
    logic [N-1:0] v;
    logic [DW-1:0] w0;
    logic [N-1:0] exp_ready;
    logic         exp_dout;
    logic         exp_valid;
    logic         exp_last;
    logic         exp_busy;
  } vec_t;

  vec_t tbl[19];
  int   t1_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

  int   g_cyc[$];
  int   g_idx[$];

  initial begin
    resetn = 1'b0; req_valid = '0; req_data = '0;
    ma = mdl_reset(); mb = mdl_reset();
    @(posedge clk);
    #1;

    // Reset holds everything at zero and grants nothing even with requests pending.
    do_reset();
    check("reset.req_ready", 64'(s_a_ready), 64'd0);
    check("reset.busy",      64'(s_a_busy),  64'd0);
    check("reset.dout_src",  64'(s_a_src),   64'd0);

    // T1 single frame, table driven.
    tbl[0] = '{1'b1, 4'b0001, 16'hA5C3, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 1'(t1_bits[i-1]), 1'b1, 1'(i == 16), 1'b1};
    tbl[17] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rn, tbl[i].v, {48'h0, tbl[i].w0});
      check($sformatf("t1[%0d].req_ready", i),  64'(s_a_ready), 64'(tbl[i].exp_ready));
      check($sformatf("t1[%0d].dout", i),       64'(s_a_dout),  64'(tbl[i].exp_dout));
      check($sformatf("t1[%0d].dout_valid", i), 64'(s_a_valid), 64'(tbl[i].exp_valid));
      check($sformatf("t1[%0d].dout_last", i),  64'(s_a_last),  64'(tbl[i].exp_last));
      check($sformatf("t1[%0d].busy", i),       64'(s_a_busy),  64'(tbl[i].exp_busy));
      if (tbl[i].exp_valid) check($sformatf("t1[%0d].dout_src", i), 64'(s_a_src), 64'd0);
    end
    idle(20);

    // T2 round robin with every requester pending: grants 0,1,2,3,0 every 18 cycles.
    do_reset();
    for (int c = 0; c < 4 * 18 + 1; c++) begin
      step(1'b1, 4'b1111, {$urandom, $urandom});
      if (s_a_ready != '0) begin
        g_cyc.push_back(c);
        for (int i = 0; i < N; i++) if (s_a_ready == N'(1 << i)) g_idx.push_back(i);
      end
    end
    check("t2.grant_count", 64'(g_cyc.size()), 64'd5);
    check("t2.onehot_count", 64'(g_idx.size()), 64'd5);
    for (int i = 0; i < g_idx.size() && i < 5; i++)
      check($sformatf("t2.grant_order[%0d]", i), 64'(g_idx[i]), 64'(i % N));
    for (int i = 1; i < g_cyc.size(); i++)
      check($sformatf("t2.spacing[%0d]", i), 64'(g_cyc[i] - g_cyc[i-1]), 64'(DW + 2));
    idle(40);

    // T3 back-to-back frames on the no-gap instance: requesters 1 and 2.
    do_reset();
    step(1'b1, 4'b0110, {16'h0000, 16'h3C5A, 16'h9E71, 16'h0000});
    check("t3.first_grant", 64'(s_b_ready), 64'b0010);
    for (int k = 0; k < 2 * DW; k++) begin
      step(1'b1, 4'b0110, {16'h0000, 16'h3C5A, 16'h9E71, 16'h0000});
      check($sformatf("t3.valid[%0d]", k), 64'(s_b_valid), 64'd1);
      check($sformatf("t3.last[%0d]", k),  64'(s_b_last),  64'(k == DW - 1 || k == 2 * DW - 1));
      check($sformatf("t3.src[%0d]", k),   64'(s_b_src),   (k < DW) ? 64'd1 : 64'd2);
      if (k == DW - 1) check("t3.boundary_grant", 64'(s_b_ready), 64'b0100);
    end
    idle(40);

    // T4 pointer skip: ptr=1, only requester 3 pending, then all pending wraps to 0.
    do_reset();
    step(1'b1, 4'b0001, {$urandom, $urandom});
    check("t4.grant0", 64'(s_a_ready), 64'b0001);
    idle(25);
    step(1'b1, 4'b1000, {$urandom, $urandom});
    check("t4.skip_to3", 64'(s_a_ready), 64'b1000);
    check("t4.skip_to3_nogap", 64'(s_b_ready), 64'b1000);
    idle(25);
    step(1'b1, 4'b1111, {$urandom, $urandom});
    check("t4.wrap_to0", 64'(s_a_ready), 64'b0001);
    idle(25);

    // T5 reset after bit 7: frame aborted, no last, next grant from pointer 0.
    do_reset();
    step(1'b1, 4'b0100, {16'h0000, 16'hFFFF, 16'h0000, 16'h0000});
    check("t5.grant2", 64'(s_a_ready), 64'b0100);
    for (int k = 0; k < 8; k++) step(1'b1, '0, '0);
    step(1'b0, 4'b1111, '0);
    check("t5.in_reset_ready", 64'(s_a_ready), 64'd0);
    step(1'b1, '0, '0);
    check("t5.valid",  64'(s_a_valid), 64'd0);
    check("t5.last",   64'(s_a_last),  64'd0);
    check("t5.dout",   64'(s_a_dout),  64'd0);
    check("t5.busy",   64'(s_a_busy),  64'd0);
    check("t5.src",    64'(s_a_src),   64'd0);
    check("t5.busy_nogap", 64'(s_b_busy), 64'd0);
    step(1'b1, 4'b1111, {$urandom, $urandom});
    check("t5.regrant0", 64'(s_a_ready), 64'b0001);
    idle(25);

    // T6 requester 2 withdraws during the gap and must not be served.
    step(1'b1, 4'b0010, {$urandom, $urandom});
    check("t6.grant1", 64'(s_a_ready), 64'b0010);
    for (int k = 0; k < DW; k++) step(1'b1, 4'b0100, {$urandom, $urandom});
    step(1'b1, 4'b0000, '0);
    check("t6.gap_busy",  64'(s_a_busy),  64'd1);
    check("t6.gap_valid", 64'(s_a_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'b0000, '0);
      check($sformatf("t6.no_frame[%0d]", k), 64'(s_a_valid | s_a_busy), 64'd0);
    end
    idle(25);

    // Random traffic with occasional resets, checked against the model every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = '0;
      step($urandom_range(0, 299) != 0, v, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
